// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed common-anode seven-segment driver.
// It has a configurable digit count and refresh prescaler. Writes are staged in
// a shadow register and committed only at frame end, so the display never tears.
// It also provides per-digit blanking, decimal points, leading-zero suppression
// and 16-step brightness.
module seven_segment_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESET,
    input  logic                  WE,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     BLANK,
    input  logic                  LZ_SUPPRESS,
    input  logic [3:0]            BRIGHT,
    output logic                  PENDING,
    output logic                  FRAME,
    output logic                  CA,
    output logic                  CB,
    output logic                  CC,
    output logic                  CD,
    output logic                  CE,
    output logic                  CF,
    output logic                  CG,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    // Hex nibble to lit segments, bit order {a,b,c,d,e,f,g}, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            4'hF:    s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan counters
    logic [PW-1:0]        pre_q, pre_d;
    logic [3:0]           sub_q, sub_d;
    logic [DW-1:0]        dig_q, dig_d;
    logic                 tick_s, sub_wrap_s, frame_end_s;

    // Shadow and active display state
    logic [4*DIGITS-1:0]  data_sh_q, data_sh_d, data_act_q, data_act_d;
    logic [DIGITS-1:0]    dp_sh_q, dp_sh_d, dp_act_q, dp_act_d;
    logic [DIGITS-1:0]    blank_sh_q, blank_sh_d, blank_act_q, blank_act_d;
    logic                 pending_q, pending_d;

    // Registered pins
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 frame_q;

    // Current-digit decode helpers
    logic [3:0]           nib_s;
    logic                 upper_zero_s;
    logic                 suppress_s;

    // Next-state for prescaler, sub-slot and digit counters, plus frame-end detect.
    always_comb begin
        tick_s      = (pre_q == PRE_LAST);
        sub_wrap_s  = tick_s && (sub_q == 4'd15);
        frame_end_s = sub_wrap_s && (dig_q == DIG_LAST);
        if (tick_s) begin
            pre_d = '0;
            sub_d = sub_q + 4'd1;
        end else begin
            pre_d = pre_q + 1'b1;
            sub_d = sub_q;
        end
        if (sub_wrap_s) begin
            if (dig_q == DIG_LAST) begin
                dig_d = '0;
            end else begin
                dig_d = dig_q + 1'b1;
            end
        end else begin
            dig_d = dig_q;
        end
    end

    // Shadow capture on WE; commit the pre-edge shadow into active at frame end.
    always_comb begin
        data_sh_d   = data_sh_q;
        dp_sh_d     = dp_sh_q;
        blank_sh_d  = blank_sh_q;
        data_act_d  = data_act_q;
        dp_act_d    = dp_act_q;
        blank_act_d = blank_act_q;
        pending_d   = pending_q;
        if (frame_end_s && pending_q) begin
            data_act_d  = data_sh_q;
            dp_act_d    = dp_sh_q;
            blank_act_d = blank_sh_q;
        end else begin
            data_act_d  = data_act_q;
        end
        // A write on the commit edge lands in the shadow and stays pending.
        if (WE) begin
            data_sh_d  = DATA;
            dp_sh_d    = DP_IN;
            blank_sh_d = BLANK;
            pending_d  = 1'b1;
        end else if (frame_end_s) begin
            pending_d  = 1'b0;
        end else begin
            pending_d  = pending_q;
        end
    end

    // Pin pattern for the current digit: blank, then zero suppression, then hex.
    always_comb begin
        nib_s        = data_act_q[{dig_q, 2'b00} +: 4];
        upper_zero_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(dig_q)) && (data_act_q[4*i +: 4] != 4'd0)) begin
                upper_zero_s = 1'b0;
            end else begin
                upper_zero_s = upper_zero_s;
            end
        end
        suppress_s = LZ_SUPPRESS && (dig_q != '0) && upper_zero_s;
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (sub_q <= BRIGHT) begin
            if (blank_act_q[dig_q]) begin
                an_d  = '1;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else if (suppress_s) begin
                // Segments stay dark; the anode is driven only to show a lone DP.
                if (dp_act_q[dig_q]) begin
                    an_d[dig_q] = 1'b0;
                    dp_d        = 1'b0;
                end else begin
                    an_d = '1;
                end
            end else begin
                an_d[dig_q] = 1'b0;
                seg_d       = ~hex_to_seg(nib_s);
                dp_d        = ~dp_act_q[dig_q];
            end
        end else begin
            an_d  = '1;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    // Scan counter registers.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            pre_q <= '0;
            sub_q <= 4'd0;
            dig_q <= '0;
        end else begin
            pre_q <= pre_d;
            sub_q <= sub_d;
            dig_q <= dig_d;
        end
    end

    // Shadow/active display registers; reset discards any pending write.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            data_sh_q   <= '0;
            dp_sh_q     <= '0;
            blank_sh_q  <= '0;
            data_act_q  <= '0;
            dp_act_q    <= '0;
            blank_act_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            data_sh_q   <= data_sh_d;
            dp_sh_q     <= dp_sh_d;
            blank_sh_q  <= blank_sh_d;
            data_act_q  <= data_act_d;
            dp_act_q    <= dp_act_d;
            blank_act_q <= blank_act_d;
            pending_q   <= pending_d;
        end
    end

    // Output pin registers, one cycle behind the scan state.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            an_q    <= '1;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_end_s;
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP      = dp_q;
    assign AN      = an_q;
    assign FRAME   = frame_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan (DIGITS=4, DIV=2, frame = 128 cycles).
// k counts non-reset clock edges since the last reset release.
// Expected pin states are queued against the edge k after which they must hold.
module tb_seven_segment_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 2;

    // Cathode patterns {CA..CG}, active-low
    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S4   = 7'b1001100;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SB   = 7'b1100000;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic                clk = 1'b0;
    logic                rst;
    logic                we;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic                lz;
    logic [3:0]          bright;
    logic                pending, frame;
    logic                ca, cb, cc, cd, ce, cf, cg, dp;
    logic [DIGITS-1:0]   an;

    typedef struct {
        int          k;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        pend;
        logic        frame;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   k = 0;
    int   tests = 0;
    int   fails = 0;

    seven_segment_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .CLK100MHZ   (clk),
        .CPU_RESET   (rst),
        .WE          (we),
        .DATA        (data),
        .DP_IN       (dp_in),
        .BLANK       (blank),
        .LZ_SUPPRESS (lz),
        .BRIGHT      (bright),
        .PENDING     (pending),
        .FRAME       (frame),
        .CA          (ca),
        .CB          (cb),
        .CC          (cc),
        .CD          (cd),
        .CE          (ce),
        .CF          (cf),
        .CG          (cg),
        .DP          (dp),
        .AN          (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Monitor: compare the queue head when its edge index arrives.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].k == k) begin
                e_m = sb.pop_front();
                tests++;
                if ({an, ca, cb, cc, cd, ce, cf, cg, dp, pending, frame} !==
                    {e_m.an, e_m.seg, e_m.dp, e_m.pend, e_m.frame}) begin
                    fails++;
                    $display("FAIL %s k=%0d got an=%b seg=%b dp=%b pend=%b frame=%b want an=%b seg=%b dp=%b pend=%b frame=%b",
                             e_m.name, k, an, {ca, cb, cc, cd, ce, cf, cg}, dp, pending, frame,
                             e_m.an, e_m.seg, e_m.dp, e_m.pend, e_m.frame);
                end
            end else if ((sb[0].k < k) && !rst) begin
                e_m = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL %s checkpoint k=%0d never reached, now k=%0d", e_m.name, e_m.k, k);
            end
        end
    end

    task automatic push(input int kk, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic p, input logic f, input string nm);
        exp_t e;
        e.k = kk; e.an = a; e.seg = s; e.dp = d; e.pend = p; e.frame = f; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_k(input int n);
        while (k < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; data = '0; dp_in = '0; blank = '0; lz = 1'b0; bright = 4'd15;
        // Reset state, then first displayed "0" on digit 0
        push(0, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(1, 4'b1110, S0, 1'b1, 1'b0, 1'b0, "post_reset_d0");

        // Scan order and frame commit of 1234
        wait_k(4);
        we = 1'b1; data = 16'h1234;
        push(5,   4'b1110, S0, 1'b1, 1'b1, 1'b0, "pending_rise");
        push(127, 4'b0111, S0, 1'b1, 1'b1, 1'b0, "pre_frame");
        push(128, 4'b0111, S0, 1'b1, 1'b0, 1'b1, "frame1_commit");
        push(129, 4'b1110, S4, 1'b1, 1'b0, 1'b0, "d0_first");
        push(160, 4'b1110, S4, 1'b1, 1'b0, 1'b0, "d0_last");
        push(161, 4'b1101, S3, 1'b1, 1'b0, 1'b0, "d1_first");
        push(193, 4'b1011, S2, 1'b1, 1'b0, 1'b0, "d2_first");
        push(225, 4'b0111, S1, 1'b1, 1'b0, 1'b0, "d3_first");
        push(256, 4'b0111, S1, 1'b1, 1'b0, 1'b1, "frame2");
        wait_k(5);
        we = 1'b0;

        // Tear-free: AAAA mid-frame, 5555 on the frame-end edge
        wait_k(269);
        we = 1'b1; data = 16'hAAAA;
        push(270, 4'b1110, S4, 1'b1, 1'b1, 1'b0, "tear_pend");
        wait_k(270);
        we = 1'b0;
        wait_k(383);
        we = 1'b1; data = 16'h5555;
        push(384, 4'b0111, S1, 1'b1, 1'b1, 1'b1, "tear_frame_pend_stays");
        push(385, 4'b1110, SA, 1'b1, 1'b1, 1'b0, "tear_commit_old");
        push(417, 4'b1101, SA, 1'b1, 1'b1, 1'b0, "tear_d1");
        push(512, 4'b0111, SA, 1'b1, 1'b0, 1'b1, "tear_frame_next");
        push(513, 4'b1110, S5, 1'b1, 1'b0, 1'b0, "tear_commit_new");
        wait_k(384);
        we = 1'b0;

        // Leading-zero suppression with DP on digit 3
        wait_k(519);
        we = 1'b1; data = 16'h0070; dp_in = 4'b1000; lz = 1'b1;
        push(520, 4'b1110, S5,   1'b1, 1'b1, 1'b0, "lz_pend");
        push(640, 4'b0111, S5,   1'b1, 1'b0, 1'b1, "lz_frame");
        push(641, 4'b1110, S0,   1'b1, 1'b0, 1'b0, "lz_d0_zero_shown");
        push(673, 4'b1101, S7,   1'b1, 1'b0, 1'b0, "lz_d1_seven");
        push(705, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "lz_d2_off");
        push(737, 4'b0111, SOFF, 1'b0, 1'b0, 1'b0, "lz_d3_dp_only");
        wait_k(520);
        we = 1'b0;

        // Brightness 3: 8 cycles lit, 24 dark per digit slot
        wait_k(768);
        bright = 4'd3;
        push(769, 4'b1110, S0,   1'b1, 1'b0, 1'b0, "br_d0_on_first");
        push(776, 4'b1110, S0,   1'b1, 1'b0, 1'b0, "br_d0_on_last");
        push(777, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "br_d0_off_first");
        push(800, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "br_d0_off_last");
        push(801, 4'b1101, S7,   1'b1, 1'b0, 1'b0, "br_d1_on");
        push(809, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "br_d1_off");
        push(865, 4'b0111, SOFF, 1'b0, 1'b0, 1'b0, "br_d3_dp_on");
        push(873, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "br_d3_off");

        // Blank digit 2, then reset mid-frame with a pending write
        wait_k(899);
        bright = 4'd15; lz = 1'b0;
        we = 1'b1; data = 16'h89AB; blank = 4'b0100; dp_in = 4'b0000;
        push(900,  4'b1110, S0,   1'b1, 1'b1, 1'b0, "blank_pend");
        push(1024, 4'b0111, S0,   1'b0, 1'b0, 1'b1, "blank_frame_lz_off");
        push(1025, 4'b1110, SB,   1'b1, 1'b0, 1'b0, "blank_d0_b");
        push(1057, 4'b1101, SA,   1'b1, 1'b0, 1'b0, "blank_d1_a");
        push(1089, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "blank_d2_first");
        push(1120, 4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "blank_d2_last");
        push(1121, 4'b0111, S8,   1'b1, 1'b0, 1'b0, "blank_d3_8");
        wait_k(900);
        we = 1'b0;
        wait_k(1129);
        we = 1'b1; data = 16'h1234;
        push(1130, 4'b0111, S8, 1'b1, 1'b1, 1'b0, "rst_pend_before");
        wait_k(1130);
        we = 1'b0;
        wait_k(1140);
        rst = 1'b1;
        push(0,   4'b1111, SOFF, 1'b1, 1'b0, 1'b0, "midrst_state");
        push(1,   4'b1110, S0,   1'b1, 1'b0, 1'b0, "midrst_d0");
        push(33,  4'b1101, S0,   1'b1, 1'b0, 1'b0, "midrst_d1");
        push(65,  4'b1011, S0,   1'b1, 1'b0, 1'b0, "midrst_d2_unblanked");
        push(97,  4'b0111, S0,   1'b1, 1'b0, 1'b0, "midrst_d3");
        push(128, 4'b0111, S0,   1'b1, 1'b0, 1'b1, "midrst_frame_discarded");
        repeat (3) @(negedge clk);
        rst = 1'b0; blank = '0;
        wait_k(130);
        @(negedge clk);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d leftover entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed driver for the board's common-anode seven-segment display. It replaces fixed-width digit muxing with a configurable digit count, refresh prescaler, per-digit blanking and decimal points, leading-zero suppression and a 16-step brightness control. Writes go to a shadow register that is committed only at frame end, so the display never shows a torn value. It sits between the SoC memory-mapped display register and the board pins (CA..CG, DP, AN).

## Interface
- DIGITS, default 8: number of digits scanned (1..8).
- DIV, default 4: CLK100MHZ cycles per brightness sub-slot (≥1). The bench uses small values; the board uses a value giving roughly a 1 kHz digit rate.
- CLK100MHZ  in  1  single system clock; all logic on its rising edge.
- CPU_RESET  in  1  reset, synchronous, active-high.
- WE  in  1  write strobe. Captures DATA, DP_IN and BLANK into the shadow register.
- DATA  in  4*DIGITS  hex nibble per digit; digit i is DATA[4i+3:4i]; digit 0 is rightmost.
- DP_IN  in  DIGITS  decimal point enable per digit (1 = lit).
- BLANK  in  DIGITS  force digit fully off (1 = off).
- LZ_SUPPRESS  in  1  leading-zero suppression enable. Sampled live, not shadowed.
- BRIGHT  in  4  duty setting; digit is lit for BRIGHT+1 of 16 sub-slots. Sampled live.
- PENDING  out  1  shadow register holds uncommitted data.
- FRAME  out  1  one-cycle pulse, coincident with the commit edge.
- CA, CB, CC, CD, CE, CF, CG  out  1 each  segment cathodes, active-low.
- DP  out  1  decimal point cathode, active-low.
- AN  out  DIGITS  digit anodes, active-low.

## Operation
- **Prescaler** `pre` counts 0..DIV-1 and wraps. `tick` = (pre == DIV-1).
- **Sub-slot counter** `sub` (4 bits) advances on tick and wraps 15→0.
- **Digit counter** `dig` advances when tick and sub==15, wrapping DIGITS-1→0.
- **Frame length** = DIGITS*16*DIV cycles.
- **Frame end** = tick && sub==15 && dig==DIGITS-1. On this edge:
  - if PENDING, the shadow contents are copied to the active register and PENDING clears;
  - FRAME is asserted for this one cycle regardless of PENDING.
- **WE** loads the shadow register and sets PENDING.
  - WE on the frame-end edge: the commit uses the shadow value from before that edge. The new write lands in the shadow and PENDING stays 1. It is committed at the next frame end.
  - Repeated WE before a commit: last write wins.
- **Digit visibility** for the current digit d, in priority order:
  - BLANK_active[d] = 1 → AN[d] = 1, all segments and DP off.
  - Suppressed: LZ_SUPPRESS = 1, d ≠ 0, and nibbles d..DIGITS-1 of the active register are all zero.
    - The 7 segments are off.
    - AN[d] = 0 only if DP_active[d] = 1, showing the DP alone; otherwise AN[d] = 1.
  - Otherwise: the nibble is hex-decoded and DP follows DP_active[d].
  - In every case, all AN bits other than d are 1.
- **Brightness**: the digit is enabled only while sub ≤ BRIGHT.
  - Outside that window, AN is all ones and the cathodes are all ones.
  - BRIGHT = 15 gives 100% duty; BRIGHT = 0 gives 1/16.
- **Hex decode** (segments a..g lit):
  - 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg;
  - 4 = bcfg; 5 = acdfg; 6 = acdefg; 7 = abc;
  - 8 = abcdefg; 9 = abcdfg; A = abcefg; b = cdefg;
  - C = adef; d = bcdeg; E = adefg; F = aefg.
  - Cathode is low when the segment is lit.

## Timing
- AN, CA..CG, DP, FRAME and PENDING are all registered. Pin outputs lag the counter state by exactly 1 cycle.
- A change in digit selection, BRIGHT or LZ_SUPPRESS appears on the pins 1 cycle after the counter or input state that caused it.
- PENDING rises on the edge that samples WE.
- Committed data first appears on the pins on the cycle after the frame-end edge. This is digit 0, sub 0, with a 1-cycle output lag.
- **Reset** (CPU_RESET high at an edge) sets:
  - pre, sub, dig = 0;
  - active and shadow registers = 0;
  - PENDING = 0, FRAME = 0;
  - AN = all ones, CA..CG = 1, DP = 1.
- Reset mid-frame aborts the scan and discards the pending data.
- The first post-reset output cycle shows digit 0 as "0", unless BLANK or brightness gating turns it off.

## Test plan
- **Reset**: DIGITS=4, DIV=2, hold CPU_RESET 3 cycles → AN=4'b1111, all cathodes 1, PENDING=0. After release, the next cycle gives AN=4'b1110 and CA..CG=0000001 ("0").
- **Scan order and frame**: BRIGHT=15, WE with DATA=16'h1234 → PENDING=1. At the frame end (cycle ≤128 after release), FRAME pulses and PENDING=0. The next frame shows digit 0 "4", then "3", "2", "1", each for 32 cycles, with AN 1110, 1101, 1011, 0111.
- **Tear-free write**: WE DATA=16'hAAAA mid-frame, then WE DATA=16'h5555 on the frame-end edge → that commit is the pre-edge shadow value 16'hAAAA; PENDING stays 1; 16'h5555 is committed one frame later.
- **Leading zeros**: DATA=16'h0070, LZ_SUPPRESS=1, DP_IN=4'b1000 → digits 0 and 1 show "0" and "7". Digit 2 has AN high. Digit 3 has AN low with only DP=0.
- **Brightness**: BRIGHT=3, DIV=2 → each digit's AN is low for 8 cycles, then high for 24 cycles of its 32-cycle slot.
- **Blank plus reset mid-frame**: BLANK=4'b0100 → AN[2] is never low. Asserting CPU_RESET mid-frame with PENDING=1 → PENDING=0 and the display returns to all "0".
